// File: rtl/fp_pkg.sv
// Shared FP types: formats, rounding modes, unrounded results, and the
// multi-cycle issue controller's op/state/response types.
package fp_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP32 = 2'd1,
    FP64 = 2'd2
  } fp_format_e;

  // Storage width of an encoded operand for the given format.
  function automatic int fp_width(input fp_format_e fmt);
    case (fmt)
      FP16:    return 16;
      FP64:    return 64;
      default: return 32;
    endcase
  endfunction

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  // Result before rounding; wide enough for every supported format.
  typedef struct packed {
    logic        sign;
    logic [12:0] exp;
    logic [55:0] mant;
    logic        sticky;
  } uround_res_t;

  typedef enum logic {
    MC_DIV  = 1'b0,
    MC_SQRT = 1'b1
  } mc_op_e;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_ISSUE = 3'd1,
    MC_WAIT  = 3'd2,
    MC_DRAIN = 3'd3,
    MC_HOLD  = 3'd4
  } mc_state_e;

  typedef struct packed {
    uround_res_t urnd;
    roundmode_e  rnd;
    logic        dz;
    logic        timeout;
  } mc_rsp_t;

endpackage

// File: rtl/fp_mc_issue.sv
// Initiator-side controller for fp_div / fp_sqrt: accepts one request,
// pulses start to the selected unit, waits for done (with timeout), and
// holds the unrounded result on a valid/ready response port for fp_rnd.
module fp_mc_issue
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT      = FP32,
  parameter int         TIMEOUT_CYCLES = 64,
  localparam int        FP_WIDTH       = fp_width(FP_FORMAT)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_op_i,
  input  logic [FP_WIDTH-1:0] req_a_i,
  input  logic [FP_WIDTH-1:0] req_b_i,
  input  roundmode_e          req_rnd_i,
  input  logic                kill_i,
  output logic [FP_WIDTH-1:0] op_a_o,
  output logic [FP_WIDTH-1:0] op_b_o,
  output roundmode_e          op_rnd_o,
  output logic                div_start_o,
  input  logic                div_done_i,
  input  uround_res_t         div_urnd_i,
  input  logic                div_dz_i,
  output logic                sqrt_start_o,
  input  logic                sqrt_done_i,
  input  uround_res_t         sqrt_urnd_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output uround_res_t         rsp_urnd_o,
  output roundmode_e          rsp_rnd_o,
  output logic                rsp_dz_o,
  output logic                rsp_timeout_o,
  output logic                busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  mc_state_e            r_state;
  mc_op_e               r_op;
  logic [FP_WIDTH-1:0]  r_op_a;
  logic [FP_WIDTH-1:0]  r_op_b;
  roundmode_e           r_op_rnd;
  logic [CNT_W-1:0]     r_cnt;
  mc_rsp_t              r_rsp;

  mc_state_e            w_state_next;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_timeout_fire;
  logic                 w_cnt_clr;
  logic                 w_cnt_en;
  logic                 w_rsp_release;
  logic                 w_done;
  logic                 w_expired;
  logic [CNT_W-1:0]     w_cnt_inc;
  uround_res_t          w_sel_urnd;

  // Only the selected unit's done/result is ever looked at.
  assign w_done     = (r_op == MC_SQRT) ? sqrt_done_i : div_done_i;
  assign w_sel_urnd = (r_op == MC_SQRT) ? sqrt_urnd_i : div_urnd_i;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_expired  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and datapath control; kill_i outranks every other transition.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    w_timeout_fire = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_en       = 1'b0;
    w_rsp_release  = 1'b0;
    case (r_state)
      MC_IDLE: begin
        if (!kill_i && req_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = MC_ISSUE;
        end
      end
      MC_ISSUE: begin
        if (kill_i) begin
          w_state_next = MC_IDLE;
        end else begin
          w_cnt_clr    = 1'b1;
          w_state_next = MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (kill_i) begin
          // A unit finishing in the kill cycle has nothing left to drain.
          w_cnt_en     = 1'b1;
          w_state_next = w_done ? MC_IDLE : MC_DRAIN;
        end else if (w_done) begin
          w_capture    = 1'b1;
          w_state_next = MC_HOLD;
        end else if (w_expired) begin
          w_timeout_fire = 1'b1;
          w_state_next   = MC_HOLD;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      MC_DRAIN: begin
        if (w_done || w_expired) begin
          w_state_next = MC_IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      MC_HOLD: begin
        if (kill_i || rsp_ready_i) begin
          w_rsp_release = 1'b1;
          w_state_next  = MC_IDLE;
        end
      end
      default: w_state_next = MC_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_i) r_state <= MC_IDLE;
    else          r_state <= w_state_next;
  end

  // Operand latch, timeout counter and response capture.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_op     <= MC_DIV;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_rnd <= RNE;
      r_cnt    <= '0;
      r_rsp    <= '{urnd: '0, rnd: RNE, dz: 1'b0, timeout: 1'b0};
    end else begin
      if (w_accept) begin
        r_op     <= mc_op_e'(req_op_i);
        r_op_a   <= req_a_i;
        r_op_b   <= req_b_i;
        r_op_rnd <= req_rnd_i;
      end
      if (w_cnt_clr)     r_cnt <= '0;
      else if (w_cnt_en) r_cnt <= w_cnt_inc;
      if (w_capture) begin
        r_rsp.urnd    <= w_sel_urnd;
        r_rsp.rnd     <= r_op_rnd;
        r_rsp.dz      <= (r_op == MC_DIV) ? div_dz_i : 1'b0;
        r_rsp.timeout <= 1'b0;
      end else if (w_timeout_fire) begin
        r_rsp.urnd    <= '0;
        r_rsp.rnd     <= r_op_rnd;
        r_rsp.dz      <= 1'b0;
        r_rsp.timeout <= 1'b1;
      end else if (w_rsp_release) begin
        r_rsp.timeout <= 1'b0;
      end
    end
  end

  assign req_ready_o   = (r_state == MC_IDLE);
  assign busy_o        = (r_state != MC_IDLE);
  assign div_start_o   = (r_state == MC_ISSUE) && (r_op == MC_DIV)  && !kill_i;
  assign sqrt_start_o  = (r_state == MC_ISSUE) && (r_op == MC_SQRT) && !kill_i;
  assign op_a_o        = r_op_a;
  assign op_b_o        = r_op_b;
  assign op_rnd_o      = r_op_rnd;
  assign rsp_valid_o   = (r_state == MC_HOLD);
  assign rsp_urnd_o    = r_rsp.urnd;
  assign rsp_rnd_o     = r_rsp.rnd;
  assign rsp_dz_o      = r_rsp.dz;
  assign rsp_timeout_o = r_rsp.timeout;

endmodule

// File: tb/tb_fp_mc_issue.sv
// Directed bench for fp_mc_issue: the bench plays the fp_div/fp_sqrt units,
// driving done/result at hand-picked WAIT cycles.
module tb_fp_mc_issue;
  import fp_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  roundmode_e  req_rnd_i;
  logic        kill_i;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  roundmode_e  op_rnd_o;
  logic        div_start_o;
  logic        div_done_i;
  uround_res_t div_urnd_i;
  logic        div_dz_i;
  logic        sqrt_start_o;
  logic        sqrt_done_i;
  uround_res_t sqrt_urnd_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  uround_res_t rsp_urnd_o;
  roundmode_e  rsp_rnd_o;
  logic        rsp_dz_o;
  logic        rsp_timeout_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  fp_mc_issue #(.FP_FORMAT(FP32), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rnd_i(req_rnd_i), .kill_i(kill_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .op_rnd_o(op_rnd_o),
    .div_start_o(div_start_o), .div_done_i(div_done_i), .div_urnd_i(div_urnd_i),
    .div_dz_i(div_dz_i),
    .sqrt_start_o(sqrt_start_o), .sqrt_done_i(sqrt_done_i), .sqrt_urnd_i(sqrt_urnd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_urnd_o(rsp_urnd_o),
    .rsp_rnd_o(rsp_rnd_o), .rsp_dz_o(rsp_dz_o), .rsp_timeout_o(rsp_timeout_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request in IDLE and advance into ISSUE.
  task automatic request(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input roundmode_e rnd);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_rnd_i   = rnd;
    step();
    req_valid_i = 1'b0;
  endtask

  uround_res_t u_div, u_sqrt, u_bp, u_rst;
  logic        seen, stable;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    u_div  = '{sign: 1'b0, exp: 13'h0080, mant: 56'hC0_0000_0000_0000, sticky: 1'b0};
    u_sqrt = '{sign: 1'b0, exp: 13'h0080, mant: 56'h80_0000_0000_0000, sticky: 1'b1};
    u_bp   = '{sign: 1'b1, exp: 13'h007E, mant: 56'h80_0000_0000_0001, sticky: 1'b0};
    u_rst  = '{sign: 1'b0, exp: 13'h1234, mant: 56'h12_3456_789A_BCDE, sticky: 1'b1};

    reset_i = 1'b0; req_valid_i = 1'b0; req_op_i = 1'b0; req_a_i = '0; req_b_i = '0;
    req_rnd_i = RNE; kill_i = 1'b0; div_done_i = 1'b0; div_urnd_i = '0; div_dz_i = 1'b0;
    sqrt_done_i = 1'b0; sqrt_urnd_i = '0; rsp_ready_i = 1'b0;

    // Reset state
    #12;
    check("rst_req_ready", req_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_starts", {div_start_o, sqrt_start_o}, 2'b00);
    check("rst_op_a", op_a_o, 32'h0);
    check("rst_op_rnd", op_rnd_o, RNE);
    check("rst_rsp_rnd", rsp_rnd_o, RNE);
    check("rst_rsp_urnd", rsp_urnd_o, '0);
    check("rst_timeout", rsp_timeout_o, 1'b0);
    step();
    reset_i = 1'b1;
    step();

    // Div: done on WAIT cycle 27, stray sqrt done on cycle 4 is ignored
    request(1'b0, 32'h40400000, 32'h3F800000, RNE);
    check("div_start_pulse", div_start_o, 1'b1);
    check("div_sqrt_start_low", sqrt_start_o, 1'b0);
    check("div_busy", busy_o, 1'b1);
    check("div_req_ready", req_ready_o, 1'b0);
    check("div_op_a", op_a_o, 32'h40400000);
    check("div_op_b", op_b_o, 32'h3F800000);
    step();                                   // WAIT cycle 1
    check("div_start_one_cycle", div_start_o, 1'b0);
    repeat (3) step();                        // cycle 4
    sqrt_done_i = 1'b1;
    step();                                   // cycle 5
    sqrt_done_i = 1'b0;
    check("div_other_done_ignored", rsp_valid_o, 1'b0);
    repeat (22) step();                       // cycle 27
    div_done_i = 1'b1; div_urnd_i = u_div; div_dz_i = 1'b0;
    #1;
    check("div_valid_not_yet", rsp_valid_o, 1'b0);
    step();
    div_done_i = 1'b0;
    check("div_rsp_valid", rsp_valid_o, 1'b1);
    check("div_rsp_urnd", rsp_urnd_o, u_div);
    check("div_rsp_rnd", rsp_rnd_o, RNE);
    check("div_rsp_dz", rsp_dz_o, 1'b0);
    check("div_rsp_timeout", rsp_timeout_o, 1'b0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check("div_back_idle", req_ready_o, 1'b1);
    check("div_valid_drop", rsp_valid_o, 1'b0);

    // Sqrt: div_dz_i high alongside sqrt done must not leak into DZ
    request(1'b1, 32'h40800000, 32'hDEADBEEF, RTZ);
    check("sqrt_start_pulse", sqrt_start_o, 1'b1);
    check("sqrt_div_start_low", div_start_o, 1'b0);
    check("sqrt_op_b", op_b_o, 32'hDEADBEEF);
    check("sqrt_op_rnd", op_rnd_o, RTZ);
    repeat (3) step();                        // WAIT cycle 3
    sqrt_done_i = 1'b1; sqrt_urnd_i = u_sqrt; div_dz_i = 1'b1;
    step();
    sqrt_done_i = 1'b0; div_dz_i = 1'b0;
    check("sqrt_rsp_valid", rsp_valid_o, 1'b1);
    check("sqrt_rsp_dz", rsp_dz_o, 1'b0);
    check("sqrt_rsp_rnd", rsp_rnd_o, RTZ);
    check("sqrt_rsp_urnd", rsp_urnd_o, u_sqrt);

    // Backpressure: new request held high for 10 HOLD cycles
    req_valid_i = 1'b1; req_op_i = 1'b0; req_a_i = 32'h3F800000;
    req_b_i = 32'h40000000; req_rnd_i = RUP;
    stable = 1'b1;
    repeat (10) begin
      step();
      if (rsp_valid_o !== 1'b1 || rsp_urnd_o !== u_sqrt || rsp_rnd_o !== RTZ ||
          req_ready_o !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    rsp_ready_i = 1'b1;
    #1;
    check("bp_no_bypass", req_ready_o, 1'b0);
    step();
    rsp_ready_i = 1'b0;
    check("bp_idle_ready", req_ready_o, 1'b1);
    check("bp_valid_drop", rsp_valid_o, 1'b0);
    step();
    req_valid_i = 1'b0;
    check("bp_accept_start", div_start_o, 1'b1);
    check("bp_op_a", op_a_o, 32'h3F800000);
    check("bp_op_rnd", op_rnd_o, RUP);
    step();
    div_done_i = 1'b1; div_urnd_i = u_bp;
    step();
    div_done_i = 1'b0;
    check("bp_rsp_urnd", rsp_urnd_o, u_bp);
    check("bp_rsp_rnd", rsp_rnd_o, RUP);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;

    // Kill in ISSUE suppresses the start pulse
    request(1'b0, 32'h40A00000, 32'h40000000, RNE);
    kill_i = 1'b1;
    #1;
    check("kill_issue_start", div_start_o, 1'b0);
    step();
    kill_i = 1'b0;
    check("kill_issue_idle", req_ready_o, 1'b1);

    // Kill on WAIT cycle 5, done on cycle 20 -> DRAIN, no response
    request(1'b0, 32'h40A00000, 32'h40000000, RNE);
    step();                                   // WAIT cycle 1
    repeat (4) step();                        // cycle 5
    kill_i = 1'b1;
    step();                                   // cycle 6, in DRAIN
    kill_i = 1'b0;
    check("kill_drain_state", dut.r_state, MC_DRAIN);
    check("kill_drain_busy", busy_o, 1'b1);
    seen = 1'b0;
    repeat (14) begin
      seen = seen | rsp_valid_o;
      step();
    end                                       // cycle 20
    div_done_i = 1'b1; div_urnd_i = u_div;
    #1;
    seen = seen | rsp_valid_o;
    check("kill_drain_not_ready", req_ready_o, 1'b0);
    step();
    div_done_i = 1'b0;
    check("kill_ready_after_done", req_ready_o, 1'b1);
    check("kill_no_rsp", {seen, rsp_valid_o}, 2'b00);

    // Timeout: no done within 64 WAIT cycles
    request(1'b0, 32'h40E00000, 32'h40000000, RDN);
    step();                                   // WAIT cycle 1
    repeat (63) step();                       // cycle 64
    check("to_not_yet", rsp_valid_o, 1'b0);
    step();
    check("to_rsp_valid", rsp_valid_o, 1'b1);
    check("to_flag", rsp_timeout_o, 1'b1);
    check("to_urnd_zero", rsp_urnd_o, '0);
    check("to_dz_zero", rsp_dz_o, 1'b0);
    check("to_rnd", rsp_rnd_o, RDN);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check("to_flag_cleared", rsp_timeout_o, 1'b0);
    check("to_idle", req_ready_o, 1'b1);

    // Done exactly on cycle 64 wins over the timeout
    request(1'b0, 32'h40E00000, 32'h00000000, RDN);
    step();                                   // WAIT cycle 1
    repeat (63) step();                       // cycle 64
    div_done_i = 1'b1; div_urnd_i = u_div; div_dz_i = 1'b1;
    step();
    div_done_i = 1'b0; div_dz_i = 1'b0;
    check("to64_valid", rsp_valid_o, 1'b1);
    check("to64_flag", rsp_timeout_o, 1'b0);
    check("to64_urnd", rsp_urnd_o, u_div);
    check("to64_dz", rsp_dz_o, 1'b1);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;

    // Asynchronous reset during WAIT
    request(1'b1, 32'h41100000, 32'h12345678, RTZ);
    repeat (2) step();                        // WAIT cycle 2
    reset_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_ready", req_ready_o, 1'b1);
    check("arst_valid", rsp_valid_o, 1'b0);
    check("arst_op_a", op_a_o, 32'h0);
    check("arst_op_b", op_b_o, 32'h0);
    check("arst_op_rnd", op_rnd_o, RNE);
    check("arst_rsp_rnd", rsp_rnd_o, RNE);
    check("arst_rsp_urnd", rsp_urnd_o, '0);
    check("arst_rsp_dz", rsp_dz_o, 1'b0);
    check("arst_starts", {div_start_o, sqrt_start_o}, 2'b00);
    repeat (2) step();
    reset_i = 1'b1;
    step();
    request(1'b1, 32'h41100000, 32'h0, RMM);
    check("arst_next_start", sqrt_start_o, 1'b1);
    repeat (2) step();                        // WAIT cycle 2
    sqrt_done_i = 1'b1; sqrt_urnd_i = u_rst;
    step();
    sqrt_done_i = 1'b0;
    check("arst_next_valid", rsp_valid_o, 1'b1);
    check("arst_next_urnd", rsp_urnd_o, u_rst);
    check("arst_next_rnd", rsp_rnd_o, RMM);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check("arst_next_idle", req_ready_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mc_issue.md
Name: fp_mc_issue

Overview:
- Initiator-side controller for the multi-cycle FP units, i.e. fp_div and fp_sqrt, which use a start/done handshake.
- Accepts one operation at a time on a valid/ready request port, then registers the operands and drives a one-cycle start pulse to the selected unit.
- Waits for that unit's done, captures its unrounded result and DZ, and presents them on a valid/ready response port.
- Sits between the FPU issue stage and fp_rnd. The rounding mode travels with the result.

Parameters:
- FP_FORMAT, FP32, selects FP_WIDTH via fp_width().
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT before a timeout response is forced. 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready; high only in IDLE
- req_op_i  in  1  0 = div, 1 = sqrt
- req_a_i  in  FP_WIDTH  operand A
- req_b_i  in  FP_WIDTH  operand B; ignored for sqrt
- req_rnd_i  in  roundmode_e  rounding mode
- kill_i  in  1  flush; abandons the in-flight operation
- op_a_o  out  FP_WIDTH  registered operand A to both units
- op_b_o  out  FP_WIDTH  registered operand B to both units
- op_rnd_o  out  roundmode_e  registered rounding mode to both units
- div_start_o  out  1  one-cycle start pulse to fp_div
- div_done_i  in  1  fp_div done
- div_urnd_i  in  uround_res_t  fp_div unrounded result
- div_dz_i  in  1  fp_div divide-by-zero
- sqrt_start_o  out  1  one-cycle start pulse to fp_sqrt
- sqrt_done_i  in  1  fp_sqrt done
- sqrt_urnd_i  in  uround_res_t  fp_sqrt unrounded result
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_urnd_o  out  uround_res_t  captured result, fed to fp_rnd
- rsp_rnd_o  out  roundmode_e  rounding mode of this response
- rsp_dz_o  out  1  DZ flag; forced 0 for sqrt
- rsp_timeout_o  out  1  set when the response was forced by timeout
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset values, applied asynchronously when reset_i=0:
  - State = IDLE.
  - All start outputs, rsp_valid_o, rsp_dz_o, rsp_timeout_o and busy_o = 0.
  - op_a_o, op_b_o, rsp_urnd_o = 0.
  - op_rnd_o, rsp_rnd_o = RNE.
  - Timeout counter = 0.
- States: IDLE, ISSUE, WAIT, DRAIN, HOLD.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: latch the operands, rounding mode and op, then go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert the start output of the selected unit only; the other start stays 0.
  - Clear the counter and go to WAIT.
- WAIT:
  - The selected unit's done is sampled each cycle; the other unit's done is ignored.
  - On done: capture the urnd result and DZ (DZ=0 for sqrt) and go to HOLD.
  - The counter increments every WAIT cycle. When it reaches TIMEOUT_CYCLES without done, go to HOLD with rsp_urnd_o=0, rsp_dz_o=0 and rsp_timeout_o=1.
- Latency: start is asserted 1 cycle after acceptance. rsp_valid_o rises the cycle after done is sampled.
- HOLD:
  - rsp_valid_o=1 and the response is stable.
  - On rsp_ready_i: go to IDLE and clear rsp_timeout_o.
  - There is no bypass: a new request is never accepted in the same cycle as a response handshake.
- kill_i has priority over every other transition:
  - In IDLE, ISSUE or HOLD: go to IDLE, drop rsp_valid_o, and suppress the start pulse in ISSUE.
  - In WAIT: go to DRAIN, because the unit is still running.
- DRAIN:
  - Wait for the selected unit's done, discard the result, then go to IDLE. No response is produced.
  - DRAIN also obeys the timeout and goes to IDLE when it expires.
- Done arriving in IDLE, ISSUE or HOLD is ignored.
- Timeout: if done arrives in the same cycle the counter expires, done wins (normal response).
- A request presented while not in IDLE is not accepted; the requester must hold it stable.
- Asynchronous reset mid-operation returns the block to IDLE with reset values. The units are reset by the same reset_i.

Decomposition:
- fp_pkg additions:
  - mc_op_e enum: MC_DIV, MC_SQRT.
  - mc_state_e enum: the five states.
  - mc_rsp_t struct: urnd, rnd, dz, timeout.
- uround_res_t and roundmode_e are reused unchanged from fp_pkg.
- No sub-module is required. The timeout counter stays inline in the FSM.

Test Plan:
- Div request A=0x40400000, B=0x3F800000, RNE, model done after 27 cycles:
  - div_start_o pulses 1 cycle after acceptance; sqrt_start_o stays 0.
  - rsp_valid_o rises the cycle after done; rsp_urnd_o equals the model output; rsp_rnd_o=RNE.
- Sqrt request A=0x40800000, B=0xDEADBEEF, RTZ, sqrt model asserts done together with div_dz_i=1:
  - rsp_dz_o=0 and rsp_rnd_o=RTZ.
  - op_b_o shows 0xDEADBEEF and is ignored.
- Backpressure: keep rsp_ready_i low 10 cycles in HOLD while req_valid_i is held high:
  - The response stays stable and req_ready_o stays 0.
  - The new request is accepted only in the cycle after the handshake.
- kill_i at WAIT cycle 5, done at cycle 20:
  - State goes to DRAIN and no rsp_valid_o is ever raised.
  - req_ready_o returns 1 the cycle after done.
- No done within 64 cycles: rsp_valid_o with rsp_timeout_o=1 and rsp_urnd_o=0. Repeat with done on exactly cycle 64: a normal response with rsp_timeout_o=0.
- Pull reset_i low during WAIT: all outputs take their reset values immediately, and the next request after release completes normally.
